// File: rtl/video_out_pkg.sv
// rtl/video_out_pkg.sv - shared types, constants and bar-colour helper for video_out_stage
//   mode_e       : source select (pass, colour bars, solid, auto)
//   lock_state_e : timing lock state machine states
//   bar_color()  : colour of a bar index for a given pixel width
//   CRC_POLY/CRC_INIT : CRC-16-CCITT constants used by the optional frame CRC
package video_out_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_AUTO  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    LOCK_UNLOCKED = 2'd0,
    LOCK_CHECKING = 2'd1,
    LOCK_LOCKED   = 2'd2
  } lock_state_e;

  localparam int          MAX_DATA_W = 96;
  localparam logic [15:0] CRC_POLY   = 16'h1021;
  localparam logic [15:0] CRC_INIT   = 16'hFFFF;

  // Pixel is R (top third), G, B (bottom third). Index bit2 lights R, bit1 G,
  // bit0 B. Returned at MAX_DATA_W; callers size-cast down to their width.
  function automatic logic [MAX_DATA_W-1:0] bar_color(input logic [2:0] idx, input int data_w);
    logic [MAX_DATA_W-1:0] c;
    int                    cw;
    c  = '0;
    cw = data_w / 3;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < data_w) begin
        if (i >= 2 * cw)  c[i] = idx[2];
        else if (i >= cw) c[i] = idx[1];
        else              c[i] = idx[0];
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/video_timing_monitor.sv
// rtl/video_timing_monitor.sv - frame-start detection, line/frame measurement and lock FSM
//   clock, reset   : video clock, asynchronous active-high reset
//   i_de, i_vs     : incoming data enable and vertical sync
//   o_frame_start  : combinational, high in the cycle i_vs rises
//   o_line_width   : line width captured at the last frame start
//   o_locked       : registered, high only in the LOCKED state
module video_timing_monitor
  import video_out_pkg::*;
#(
  parameter int H_W         = 12,
  parameter int V_W         = 12,
  parameter int LOCK_FRAMES = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           i_de,
  input  logic           i_vs,
  output logic           o_frame_start,
  output logic [H_W-1:0] o_line_width,
  output logic           o_locked
);

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_FRAMES);

  logic           de_q, vs_q;
  logic [H_W-1:0] pix_q, width_q, frame_width_q;
  logic [V_W-1:0] line_q, frame_height_q;
  logic [3:0]     match_cnt_q;
  lock_state_e    state_q;
  logic           locked_q;

  logic           de_fall, frame_start, match;
  logic [H_W-1:0] width_d;
  logic [V_W-1:0] line_d;
  logic [3:0]     match_cnt_d;

  assign de_fall     = de_q & ~i_de;
  assign frame_start = i_vs & ~vs_q;

  // A line ending in the same cycle as the frame start belongs to the
  // finishing frame, so measure with the already-updated values.
  assign width_d     = de_fall ? pix_q : width_q;
  assign line_d      = (de_fall && line_q != '1) ? line_q + V_W'(1) : line_q;
  assign match       = (width_d == frame_width_q) && (line_d == frame_height_q) &&
                       (width_d != '0) && (line_d != '0);
  assign match_cnt_d = (match_cnt_q == LOCK_TARGET) ? match_cnt_q : match_cnt_q + 4'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      de_q           <= 1'b0;
      vs_q           <= 1'b0;
      pix_q          <= '0;
      width_q        <= '0;
      line_q         <= '0;
      frame_width_q  <= '0;
      frame_height_q <= '0;
    end else begin
      de_q <= i_de;
      vs_q <= i_vs;
      if (de_fall) begin
        width_q <= pix_q;
        pix_q   <= '0;
      end else if (i_de && pix_q != '1) begin
        pix_q <= pix_q + H_W'(1);
      end
      if (frame_start) begin
        frame_width_q  <= width_d;
        frame_height_q <= line_d;
        line_q         <= '0;
      end else begin
        line_q <= line_d;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= LOCK_UNLOCKED;
      match_cnt_q <= '0;
      locked_q    <= 1'b0;
    end else if (frame_start) begin
      if (!match) begin
        state_q     <= LOCK_UNLOCKED;
        match_cnt_q <= '0;
        locked_q    <= 1'b0;
      end else begin
        match_cnt_q <= match_cnt_d;
        case (state_q)
          LOCK_UNLOCKED, LOCK_CHECKING: begin
            if (match_cnt_d == LOCK_TARGET) begin
              state_q  <= LOCK_LOCKED;
              locked_q <= 1'b1;
            end else begin
              state_q  <= LOCK_CHECKING;
            end
          end
          default: begin
            state_q  <= LOCK_LOCKED;
            locked_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_frame_start = frame_start;
  assign o_line_width  = frame_width_q;
  assign o_locked      = locked_q;

endmodule

// File: rtl/video_out_stage.sv
// rtl/video_out_stage.sv - video output stage: source mux, fixed-latency pipeline, lock and frame count
//   clock, reset              : video clock, asynchronous active-high reset
//   i_data/i_de/i_hs/i_vs     : incoming pixel stream
//   i_mode, i_bg_color        : source select (frame-synchronous) and solid colour
//   o_data/o_de/o_hs/o_vs     : outputs, LATENCY cycles after the inputs
//   o_locked, o_frame_count   : timing lock status and frame counter
//   o_frame_crc               : per-frame CRC-16, only with VIDEO_OUT_STAGE_CRC_EN defined
module video_out_stage
  import video_out_pkg::*;
#(
  parameter int DATA_W      = 24,
  parameter int LATENCY     = 2,
  parameter int H_W         = 12,
  parameter int V_W         = 12,
  parameter int LOCK_FRAMES = 4,
  parameter int BAR_LOG2    = 3,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_de,
  input  logic                   i_hs,
  input  logic                   i_vs,
  input  logic [1:0]             i_mode,
  input  logic [DATA_W-1:0]      i_bg_color,
  output logic [DATA_W-1:0]      o_data,
  output logic                   o_de,
  output logic                   o_hs,
  output logic                   o_vs,
  output logic                   o_locked,
  output logic [FRAME_CNT_W-1:0] o_frame_count
`ifdef VIDEO_OUT_STAGE_CRC_EN
  ,
  output logic [15:0]            o_frame_crc
`endif
);

  logic             frame_start, mon_locked;
  logic [H_W-1:0]   line_width;

  video_timing_monitor #(
    .H_W         (H_W),
    .V_W         (V_W),
    .LOCK_FRAMES (LOCK_FRAMES)
  ) u_monitor (
    .clock         (clock),
    .reset         (reset),
    .i_de          (i_de),
    .i_vs          (i_vs),
    .o_frame_start (frame_start),
    .o_line_width  (line_width),
    .o_locked      (mon_locked)
  );

  mode_e                  mode_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_count_q;
  logic                   locked_q;
  logic [H_W-1:0]         bar_cnt_q, bar_w_d, bar_shift;
  logic [BAR_LOG2-1:0]    bar_idx_q;
  logic [DATA_W-1:0]      bar_data_d, src_data_d;
  logic [DATA_W-1:0]      data_pipe_q [LATENCY];
  logic [2:0]             ctl_pipe_q  [LATENCY];

  assign bar_shift  = line_width >> BAR_LOG2;
  assign bar_w_d    = (bar_shift == '0) ? H_W'(1) : bar_shift;
  assign bar_data_d = DATA_W'(bar_color(3'(bar_idx_q), DATA_W));

  always_comb begin
    src_data_d = '0;
    if (i_de) begin
      case (mode_q)
        MODE_PASS:  src_data_d = i_data;
        MODE_BARS:  src_data_d = bar_data_d;
        MODE_SOLID: src_data_d = i_bg_color;
        default:    src_data_d = mon_locked ? i_data : bar_data_d;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q        <= MODE_PASS;
      frame_cnt_q   <= '0;
      frame_count_q <= '0;
      locked_q      <= 1'b0;
      bar_cnt_q     <= '0;
      bar_idx_q     <= '0;
    end else begin
      if (frame_start) begin
        mode_q      <= mode_e'(i_mode);
        frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
      end
      // Status outputs trail the internal frame-start update by one cycle.
      frame_count_q <= frame_cnt_q;
      locked_q      <= mon_locked;
      if (!i_de) begin
        bar_cnt_q <= '0;
        bar_idx_q <= '0;
      end else if (bar_cnt_q == bar_w_d - H_W'(1)) begin
        bar_cnt_q <= '0;
        if (bar_idx_q != '1) bar_idx_q <= bar_idx_q + BAR_LOG2'(1);
      end else begin
        bar_cnt_q <= bar_cnt_q + H_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LATENCY; k++) begin
        data_pipe_q[k] <= '0;
        ctl_pipe_q[k]  <= '0;
      end
    end else begin
      data_pipe_q[0] <= src_data_d;
      ctl_pipe_q[0]  <= {i_de, i_hs, i_vs};
      for (int k = 1; k < LATENCY; k++) begin
        data_pipe_q[k] <= data_pipe_q[k-1];
        ctl_pipe_q[k]  <= ctl_pipe_q[k-1];
      end
    end
  end

  assign o_data        = data_pipe_q[LATENCY-1];
  assign o_de          = ctl_pipe_q[LATENCY-1][2];
  assign o_hs          = ctl_pipe_q[LATENCY-1][1];
  assign o_vs          = ctl_pipe_q[LATENCY-1][0];
  assign o_locked      = locked_q;
  assign o_frame_count = frame_count_q;

`ifdef VIDEO_OUT_STAGE_CRC_EN
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [DATA_W-1:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

  logic        crc_vs_q;
  logic [15:0] crc_q, crc_out_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc_vs_q  <= 1'b0;
      crc_q     <= CRC_INIT;
      crc_out_q <= '0;
    end else begin
      crc_vs_q <= o_vs;
      if (o_vs && !crc_vs_q) begin
        crc_out_q <= crc_q;
        crc_q     <= o_de ? crc_step(CRC_INIT, o_data) : CRC_INIT;
      end else if (o_de) begin
        crc_q <= crc_step(crc_q, o_data);
      end
    end
  end

  assign o_frame_crc = crc_out_q;
`endif

endmodule

// File: doc/video_out_stage.md
# video_out_stage

Parametrised video output stage between the pixel generator and the RGB pins, on the video clock. Delays data and syncs by a fixed latency. Measures incoming active timing to report lock and counts frames. Can substitute colour bars or a solid background per a frame-synchronous mode.

## Interface
- DATA_W, 24: pixel width; must be a multiple of 3, split equally as R (MSB), G, B.
- LATENCY, 2: input-to-output pipeline depth in cycles; must be 1 or more.
- H_W, 12: width of the active-pixel-per-line counter.
- V_W, 12: width of the active-line-per-frame counter.
- LOCK_FRAMES, 4: consecutive matching frames required for lock; range 1–15.
- BAR_LOG2, 3: colour bar count is 2^BAR_LOG2.
- FRAME_CNT_W, 16: frame counter width.
- clock  in  1  video clock.
- reset  in  1  asynchronous, active-high.
- i_data  in  DATA_W  pixel in.
- i_de  in  1  data enable.
- i_hs  in  1  horizontal sync; active-high.
- i_vs  in  1  vertical sync; active-high.
- i_mode  in  2  source select: 0 pass, 1 colour bars, 2 solid, 3 auto (pass if locked, else bars).
- i_bg_color  in  DATA_W  colour used in solid mode.
- o_data  out  DATA_W  pixel out.
- o_de, o_hs, o_vs  out  1 each  i_de, i_hs, i_vs delayed by LATENCY cycles.
- o_locked  out  1  input timing stable.
- o_frame_count  out  FRAME_CNT_W  frame count.

## Operation
- Frame start is the rising edge of i_vs, detected against the registered previous i_vs.
- i_mode is sampled into an internal mode register only at frame start. Mid-frame changes are ignored until the next frame start.
- **Measurement**
  - The pixel counter counts i_de-high cycles in a line. On the falling edge of i_de it is stored as line width and cleared.
  - The line counter counts i_de falling edges. At frame start it is stored as frame height and cleared.
  - Both counters saturate at all-ones.
  - A frame with zero lines stores height 0.
- **Lock state machine**, evaluated at each frame start (states UNLOCKED, CHECKING, LOCKED):
  - Match means the current width and height equal the previous frame's, and both are nonzero.
  - A match increments the match count, saturating at LOCK_FRAMES.
  - A mismatch clears the match count and forces UNLOCKED.
  - UNLOCKED → CHECKING on the first match.
  - CHECKING → LOCKED when the match count reaches LOCK_FRAMES.
  - o_locked is 1 only in LOCKED.
- **Colour bars**
  - Bar width is the previous frame's line width >> BAR_LOG2, with a minimum of 1.
  - Within an active line, a bar index advances each time the in-bar counter reaches bar width − 1. The index clamps at 2^BAR_LOG2 − 1 and resets to 0 when i_de is low.
  - Bar colour: index bit2 gives R all-ones, bit1 gives G, bit0 gives B; other channels 0. For BAR_LOG2 > 3 only bits [2:0] are used.
- **Source mux**
  - Substitution applies only where de is high. When de is low, o_data = 0 in every mode.
  - Syncs and de are never altered.
- The frame counter increments at each frame start and wraps modulo 2^FRAME_CNT_W.

## Timing
- o_data, o_de, o_hs and o_vs are exactly LATENCY cycles after the inputs, in all modes and mode transitions.
- o_locked and o_frame_count update 1 cycle after the clock edge on which the i_vs rising edge is sampled.
- Reset, asynchronous:
  - All outputs are 0, all counters are 0, the mode register is 0 (pass), and the lock state is UNLOCKED.
  - Measured width and height are 0, so the first post-reset frame cannot match.
  - Pipeline registers are cleared.
- Reset mid-frame: the partial frame after release is measured normally. It generally mismatches, so lock requires LOCK_FRAMES + 1 full frames.
- Simultaneous i_vs rise and i_de fall: the line count includes that line before it is stored.

## Configuration
- VIDEO_OUT_STAGE_CRC_EN defined:
  - Adds output o_frame_crc[15:0].
  - It is CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first) over o_data on every cycle with o_de high, processing DATA_W bits per cycle.
  - At the o_vs rising edge the value is latched to o_frame_crc and the running CRC re-initialised.
  - Reset value of o_frame_crc is 0.
- Undefined: the port and all CRC logic are absent.

## Structure
- Package video_out_pkg holds:
  - mode enum (MODE_PASS, MODE_BARS, MODE_SOLID, MODE_AUTO);
  - lock state enum;
  - a bar-colour function of index and DATA_W;
  - the CRC polynomial and init constants.
- One sub-module, video_timing_monitor, owns edge detection, width/height measurement and the lock FSM. It exports frame_start, line width and lock.

## Test plan
- **Lock:** 16x4-active frames repeated, LOCKED = 1 → o_locked rises at frame start 3 (the first match); o_frame_count reads 1, 2, 3 at starts 1–3.
- **Unlock:** locked, then one frame of 16x3 → o_locked = 0 at that frame's end; relocks only after LOCK_FRAMES further matching 16x3 frames.
- **Bars:** mode 1, width 16, BAR_LOG2 = 3, DATA_W = 24 → o_data per pixel pair: 000000, 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, FFFFFF.
- **Mode timing:** mode 2 with i_bg_color = 123456 written mid-frame → pass data until the next i_vs rise, then 123456 on every de pixel; o_data = 0 where de is low.
- **Latency:** LATENCY = 3 with random syncs and data in mode 0 → outputs equal inputs delayed exactly 3 cycles.
- **Auto and reset:** mode 3 unlocked shows bars and locked shows pass; asserting reset mid-line zeroes all outputs within the same cycle, with no clock edge needed.
